// File: rtl/fetch_sequencer.sv
// fetch_sequencer: control FSM that steps the program counter through
// fetch, issue and update. It drives the PC's clear/load/increment controls,
// runs a req/ack exchange with instruction memory and hands each fetched
// word to decode over valid/ready.
//
// Handshakes: a request (imem_req / instr_valid) is raised by this block and
// held, with its address/data stable, until the partner's ack/ready is seen
// high on a rising edge; the request drops on the following cycle. An ack or
// ready seen while the matching request is low has no effect.
module fetch_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              run,
    input  logic [ADDR_W-1:0] pc_q,
    output logic              pc_clr,
    output logic              pc_ld,
    output logic              pc_inc,
    output logic [ADDR_W-1:0] pc_d,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic              fault,
    output logic [31:0]       retired
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        ISSUE  = 3'd2,
        UPDATE = 3'd3,
        FAULT  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              br_taken_r;
    logic [ADDR_W-1:0] tgt_r;

    // The PC clears on the same edge that resets this block.
    assign pc_clr = ~clr_n;

    // Next-state selection; run is looked at only in IDLE and UPDATE so a
    // started instruction always completes.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run) state_nxt = FETCH;
            FETCH:   if (imem_ack) state_nxt = ISSUE;
            ISSUE: begin
                if (instr_ready) begin
                    if (br_taken && (br_target[1:0] != 2'b00)) state_nxt = FAULT;
                    else                                       state_nxt = UPDATE;
                end
            end
            UPDATE:  state_nxt = run ? FETCH : IDLE;
            FAULT:   state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the current state and the captured branch registers.
    always_comb begin
        imem_req    = 1'b0;
        imem_addr   = '0;
        instr_valid = 1'b0;
        pc_ld       = 1'b0;
        pc_inc      = 1'b0;
        pc_d        = '0;
        fault       = 1'b0;
        case (state)
            FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc_q;
            end
            ISSUE:  instr_valid = 1'b1;
            UPDATE: begin
                pc_ld  = 1'b1;
                pc_inc = ~br_taken_r;
                pc_d   = br_taken_r ? tgt_r : pc_q;
            end
            FAULT:  fault = 1'b1;
            default: ;
        endcase
    end

    // State register plus the datapath captured at each handshake.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state      <= IDLE;
            instr      <= '0;
            br_taken_r <= 1'b0;
            tgt_r      <= '0;
            retired    <= '0;
        end else begin
            state <= state_nxt;
            if (state == FETCH && imem_ack) begin
                instr <= imem_rdata;
            end
            if (state == ISSUE && instr_ready) begin
                br_taken_r <= br_taken;
                tgt_r      <= br_target;
            end
            if (state == UPDATE) begin
                retired <= retired + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small PC and instruction memory
// alongside the DUT.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        run;
    logic [31:0] pc_q = '0;
    logic        pc_clr;
    logic        pc_ld;
    logic        pc_inc;
    logic [31:0] pc_d;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        br_taken;
    logic [31:0] br_target;
    logic        fault;
    logic [31:0] retired;

    int          n_checks = 0;
    int          n_errors = 0;
    int          ack_delay = 0;
    int          wait_cnt = 0;

    fetch_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .clr_n(clr_n), .run(run), .pc_q(pc_q),
        .pc_clr(pc_clr), .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_d(pc_d),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .br_taken(br_taken), .br_target(br_target),
        .fault(fault), .retired(retired)
    );

    // clock
    always #5 clk = ~clk;

    // program counter: clear, load, or load+4
    always @(posedge clk) begin
        if (pc_clr)     pc_q <= '0;
        else if (pc_ld) pc_q <= pc_inc ? (pc_d + 32'd4) : pc_d;
    end

    // memory: acks after ack_delay cycles of a held request
    always @(posedge clk) begin
        if (!imem_req || imem_ack) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end
    assign imem_ack   = imem_req && (wait_cnt >= ack_delay);
    assign imem_rdata = 32'hC0DE_0000 | {16'h0, imem_addr[15:0]};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        clr_n = 1'b0; run = 1'b0; instr_ready = 1'b1;
        br_taken = 1'b0; br_target = '0;
        #1;
        check("rst_pc_clr", {31'b0, pc_clr}, 32'd1);
        tick();
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_pc_ld", {31'b0, pc_ld}, 32'd0);
        check("rst_fault", {31'b0, fault}, 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", pc_q, 32'd0);

        // sequential run, immediate ack, ready high
        clr_n = 1'b1; run = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("seq_req", {31'b0, imem_req}, 32'd1);
            check("seq_addr", imem_addr, 32'(4 * i));
            tick();
            check("seq_valid", {31'b0, instr_valid}, 32'd1);
            check("seq_instr", instr, 32'hC0DE_0000 | 32'(4 * i));
            tick();
            check("seq_pc_ld", {31'b0, pc_ld}, 32'd1);
            check("seq_pc_inc", {31'b0, pc_inc}, 32'd1);
            check("seq_pc_d", pc_d, 32'(4 * i));
            tick();
        end
        check("seq_retired", retired, 32'd4);
        check("seq_pc", pc_q, 32'd16);

        // ack delayed 5 cycles, then ready held low 2 cycles, then a branch
        ack_delay = 5;
        #0;
        for (int k = 0; k < 5; k++) begin
            check("dly_ack", {31'b0, imem_ack}, 32'd0);
            check("dly_req", {31'b0, imem_req}, 32'd1);
            check("dly_addr", imem_addr, 32'd16);
            check("dly_pc_ld", {31'b0, pc_ld}, 32'd0);
            tick();
        end
        check("dly_ack_now", {31'b0, imem_ack}, 32'd1);
        instr_ready = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            check("rdy_valid", {31'b0, instr_valid}, 32'd1);
            check("rdy_instr", instr, 32'hC0DE_0010);
            tick();
        end
        instr_ready = 1'b1; br_taken = 1'b1; br_target = 32'h40;
        tick();
        br_taken = 1'b0; br_target = '0;
        check("br_pc_ld", {31'b0, pc_ld}, 32'd1);
        check("br_pc_inc", {31'b0, pc_inc}, 32'd0);
        check("br_pc_d", pc_d, 32'h40);
        tick();
        check("br_addr", imem_addr, 32'h40);
        check("br_retired", retired, 32'd5);

        // misaligned target -> sticky fault
        ack_delay = 0;
        tick();
        check("flt_instr", instr, 32'hC0DE_0040);
        br_taken = 1'b1; br_target = 32'h42;
        tick();
        br_taken = 1'b0; br_target = '0;
        for (int k = 0; k < 3; k++) begin
            check("flt_fault", {31'b0, fault}, 32'd1);
            check("flt_pc_ld", {31'b0, pc_ld}, 32'd0);
            check("flt_req", {31'b0, imem_req}, 32'd0);
            check("flt_valid", {31'b0, instr_valid}, 32'd0);
            tick();
        end
        check("flt_pc", pc_q, 32'h40);
        check("flt_retired", retired, 32'd5);
        clr_n = 1'b0; run = 1'b0;
        tick();
        clr_n = 1'b1;
        check("flt_clr_fault", {31'b0, fault}, 32'd0);
        check("flt_clr_pc", pc_q, 32'd0);
        check("flt_clr_retired", retired, 32'd0);
        tick();
        check("flt_idle_req", {31'b0, imem_req}, 32'd0);

        // run dropped during FETCH: one instruction finishes, then IDLE
        run = 1'b1;
        tick();
        check("stop_req", {31'b0, imem_req}, 32'd1);
        run = 1'b0; ack_delay = 2;
        tick();
        check("stop_req_held", {31'b0, imem_req}, 32'd1);
        tick();
        tick();
        check("stop_valid", {31'b0, instr_valid}, 32'd1);
        tick();
        check("stop_pc_ld", {31'b0, pc_ld}, 32'd1);
        tick();
        check("stop_idle_req", {31'b0, imem_req}, 32'd0);
        check("stop_pc", pc_q, 32'd4);
        check("stop_retired", retired, 32'd1);
        tick();
        check("stop_idle_req2", {31'b0, imem_req}, 32'd0);
        check("stop_pc_hold", pc_q, 32'd4);

        // reset during ISSUE
        run = 1'b1; ack_delay = 0; instr_ready = 1'b0;
        tick();
        check("mid_addr", imem_addr, 32'd4);
        tick();
        check("mid_valid", {31'b0, instr_valid}, 32'd1);
        clr_n = 1'b0;
        #1;
        check("mid_pc_clr", {31'b0, pc_clr}, 32'd1);
        tick();
        clr_n = 1'b1; run = 1'b0;
        check("mid_valid_off", {31'b0, instr_valid}, 32'd0);
        check("mid_retired", retired, 32'd0);
        check("mid_pc", pc_q, 32'd0);
        check("mid_instr", instr, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
